// File: rtl/pwm_cfg_pkg.sv
// Shared constants for the PWM configuration register bank.
// Register-select codes, parser state encoding and frequency codes.
package pwm_cfg_pkg;

  localparam logic [1:0] REG_SELECT = 2'b00;
  localparam logic [1:0] REG_COUNT  = 2'b01;
  localparam logic [1:0] REG_COMMIT = 2'b10;
  localparam logic [1:0] REG_RSVD   = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SEL_DATA = 3'd1;
  localparam logic [2:0] ST_CNT_HI   = 3'd2;
  localparam logic [2:0] ST_CNT_LO   = 3'd3;
  localparam logic [2:0] ST_DISCARD  = 3'd4;

  localparam logic [7:0] FREQ_50HZ   = 8'd0;
  localparam logic [7:0] FREQ_120HZ  = 8'd1;
  localparam logic [7:0] FREQ_200HZ  = 8'd2;
  localparam logic [7:0] FREQ_400HZ  = 8'd3;
  localparam logic [7:0] FREQ_1000HZ = 8'd4;
  localparam logic [7:0] FREQ_2000HZ = 8'd5;
  localparam logic [7:0] FREQ_4000HZ = 8'd6;

  typedef struct packed {
    logic        en;
    logic        is_count;
    logic [5:0]  chan;
    logic [15:0] data;
  } cfg_wr_t;

  function automatic logic chan_ok(
    input logic [5:0] chan,
    input int         n
  );
    return {1'b0, chan} < 7'(n);
  endfunction

endpackage

// File: rtl/pwm_cfg_frame_parser.sv
// Byte-stream frame parser: decodes address byte, collects data,
// emits shadow write strobes and a commit strobe.
module pwm_cfg_frame_parser
  import pwm_cfg_pkg::*;
#(
  parameter int Channels = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_fire,
  input  logic       frame_start,
  output cfg_wr_t    wr,
  output logic       commit
`ifdef PWM_CFG_ERRCNT_EN
  ,
  output logic       err
`endif
);

  logic [2:0] state;
  logic [2:0] cur;
  logic [2:0] nxt;
  logic [5:0] chan_q;
  logic [7:0] temp_q;
  logic       ok;

  // A frame start overrides whatever state the parser was left in,
  // so a byte arriving with it is treated as an address byte.
  assign cur = frame_start ? ST_IDLE : state;
  assign ok  = chan_ok(rx_data[5:0], Channels);

  // Decode the accepted byte against the effective state.
  always_comb begin
    nxt    = cur;
    wr     = '0;
    commit = 1'b0;
    if (rx_fire) begin
      unique case (cur)
        ST_IDLE: begin
          unique case (rx_data[7:6])
            REG_SELECT: nxt = ok ? ST_SEL_DATA : ST_DISCARD;
            REG_COUNT:  nxt = ok ? ST_CNT_HI : ST_DISCARD;
            REG_COMMIT: begin
              commit = 1'b1;
              nxt    = ST_DISCARD;
            end
            default:    nxt = ST_DISCARD;
          endcase
        end
        ST_SEL_DATA: begin
          wr.en   = 1'b1;
          wr.chan = chan_q;
          wr.data = {8'h00, rx_data};
          nxt     = ST_DISCARD;
        end
        ST_CNT_HI: nxt = ST_CNT_LO;
        ST_CNT_LO: begin
          wr.en       = 1'b1;
          wr.is_count = 1'b1;
          wr.chan     = chan_q;
          wr.data     = {temp_q, rx_data};
          nxt         = ST_DISCARD;
        end
        default: nxt = ST_DISCARD;
      endcase
    end
  end

`ifdef PWM_CFG_ERRCNT_EN
  assign err = rx_fire && (cur == ST_IDLE) &&
               ((rx_data[7:6] == REG_RSVD) ||
                (!rx_data[7] && !ok));
`endif

  // State, latched channel and high count byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      chan_q <= '0;
      temp_q <= '0;
    end else begin
      state <= nxt;
      if (rx_fire && cur == ST_IDLE)
        chan_q <= rx_data[5:0];
      if (rx_fire && cur == ST_CNT_HI)
        temp_q <= rx_data;
    end
  end

endmodule

// File: rtl/pwm_config_regs.sv
// PWM config bank: shadow registers, commit-on-period-boundary.
// Optional error counter enabled by PWM_CFG_ERRCNT_EN.
module pwm_config_regs
  import pwm_cfg_pkg::*;
#(
  parameter int          Channels      = 8,
  parameter logic [7:0]  DefaultSelect = FREQ_4000HZ,
  parameter logic [15:0] DefaultCount  = 16'd0
) (
  input  logic                   CLK,
  input  logic                   _RST,
  input  logic [7:0]             RxByte,
  input  logic                   RxValid,
  output logic                   RxReady,
  input  logic                   FrameStart,
  input  logic                   PeriodEnd,
  output logic [8*Channels-1:0]  SelectOut,
  output logic [16*Channels-1:0] CountOut,
  output logic                   CommitPending
`ifdef PWM_CFG_ERRCNT_EN
  ,
  output logic [7:0]             ErrCount
`endif
);

  logic [7:0]  sel_sh  [Channels];
  logic [15:0] cnt_sh  [Channels];
  logic [7:0]  sel_act [Channels];
  logic [15:0] cnt_act [Channels];

  cfg_wr_t wr;
  logic    commit;
  logic    rx_fire;
  logic    apply;
  logic    pend_q;
  logic    ready_q;

  assign rx_fire       = RxValid & ready_q;
  assign apply         = PeriodEnd & pend_q;
  assign RxReady       = ready_q;
  assign CommitPending = pend_q;

`ifdef PWM_CFG_ERRCNT_EN
  logic       err;
  logic [7:0] err_q;
`endif

  pwm_cfg_frame_parser #(
    .Channels (Channels)
  ) u_parser (
    .clk         (CLK),
    .rst_n       (_RST),
    .rx_data     (RxByte),
    .rx_fire     (rx_fire),
    .frame_start (FrameStart),
    .wr          (wr),
    .commit      (commit)
`ifdef PWM_CFG_ERRCNT_EN
    ,
    .err         (err)
`endif
  );

  // Shadow copies take parser writes for the addressed channel.
  always_ff @(posedge CLK) begin
    if (!_RST) begin
      for (int i = 0; i < Channels; i++) begin
        sel_sh[i] <= DefaultSelect;
        cnt_sh[i] <= DefaultCount;
      end
    end else if (wr.en) begin
      for (int i = 0; i < Channels; i++) begin
        if (wr.chan == 6'(i)) begin
          if (wr.is_count)
            cnt_sh[i] <= wr.data;
          else
            sel_sh[i] <= wr.data[7:0];
        end
      end
    end
  end

  // Active outputs copy every shadow at once on a pending boundary.
  always_ff @(posedge CLK) begin
    if (!_RST) begin
      for (int i = 0; i < Channels; i++) begin
        sel_act[i] <= DefaultSelect;
        cnt_act[i] <= DefaultCount;
      end
    end else if (apply) begin
      for (int i = 0; i < Channels; i++) begin
        sel_act[i] <= sel_sh[i];
        cnt_act[i] <= cnt_sh[i];
      end
    end
  end

  // Pending commit holds off the byte stream until it is applied.
  // Commit and apply never coincide since no byte is taken while
  // pending.
  always_ff @(posedge CLK) begin
    if (!_RST) begin
      pend_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (commit) begin
      pend_q  <= 1'b1;
      ready_q <= 1'b0;
    end else if (apply) begin
      pend_q  <= 1'b0;
      ready_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < Channels; g++) begin : g_out
    assign SelectOut[8*g +: 8]  = sel_act[g];
    assign CountOut[16*g +: 16] = cnt_act[g];
  end

`ifdef PWM_CFG_ERRCNT_EN
  // Saturating count of invalid address bytes.
  always_ff @(posedge CLK) begin
    if (!_RST)
      err_q <= '0;
    else if (err && err_q != 8'hFF)
      err_q <= err_q + 8'd1;
  end

  assign ErrCount = err_q;
`endif

endmodule

// File: tb/tb_pwm_config_regs.sv
// Randomized bench for pwm_config_regs against a frame-level model.
// ErrCount checks are compiled in with PWM_CFG_ERRCNT_EN.
module tb_pwm_config_regs;

  localparam int CH = 8;

  logic              CLK = 1'b0;
  logic              _RST;
  logic [7:0]        RxByte;
  logic              RxValid;
  logic              RxReady;
  logic              FrameStart;
  logic              PeriodEnd;
  logic [8*CH-1:0]   SelectOut;
  logic [16*CH-1:0]  CountOut;
  logic              CommitPending;
`ifdef PWM_CFG_ERRCNT_EN
  logic [7:0]        ErrCount;
`endif

  always #5 CLK = ~CLK;

  pwm_config_regs #(
    .Channels      (CH),
    .DefaultSelect (8'd6),
    .DefaultCount  (16'd0)
  ) dut (
    .CLK           (CLK),
    ._RST          (_RST),
    .RxByte        (RxByte),
    .RxValid       (RxValid),
    .RxReady       (RxReady),
    .FrameStart    (FrameStart),
    .PeriodEnd     (PeriodEnd),
    .SelectOut     (SelectOut),
    .CountOut      (CountOut),
    .CommitPending (CommitPending)
`ifdef PWM_CFG_ERRCNT_EN
    ,
    .ErrCount      (ErrCount)
`endif
  );

  // Frame-level reference model
  logic [7:0]  m_sel_sh [CH];
  logic [15:0] m_cnt_sh [CH];
  logic [7:0]  m_sel    [CH];
  logic [15:0] m_cnt    [CH];
  logic        m_pend;
  int          m_err;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < CH; i++) begin
      m_sel_sh[i] = 8'd6;
      m_sel[i]    = 8'd6;
      m_cnt_sh[i] = 16'd0;
      m_cnt[i]    = 16'd0;
    end
    m_pend = 1'b0;
    m_err  = 0;
  endfunction

  function automatic void m_bump_err();
    if (m_err < 255) m_err++;
  endfunction

  // Whole-frame effect: address byte decides, extra bytes ignored,
  // short frames write nothing.
  function automatic void m_frame(input logic [7:0] f[$]);
    int rs;
    int ch;
    if (f.size() == 0) return;
    rs = int'(f[0] >> 6);
    ch = int'(f[0] & 8'h3F);
    if (rs == 2) begin
      m_pend = 1'b1;
    end else if (rs == 3 || ch >= CH) begin
      m_bump_err();
    end else if (rs == 0) begin
      if (f.size() >= 2) m_sel_sh[ch] = f[1];
    end else begin
      if (f.size() >= 3) m_cnt_sh[ch] = {f[1], f[2]};
    end
  endfunction

  function automatic void m_period();
    if (m_pend) begin
      for (int i = 0; i < CH; i++) begin
        m_sel[i] = m_sel_sh[i];
        m_cnt[i] = m_cnt_sh[i];
      end
      m_pend = 1'b0;
    end
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("%s_sel%0d", tag, i), SelectOut[8*i +: 8], m_sel[i]);
      chk($sformatf("%s_cnt%0d", tag, i), CountOut[16*i +: 16], m_cnt[i]);
    end
    chk({tag, "_pend"}, CommitPending, m_pend);
    chk({tag, "_ready"}, RxReady, !m_pend);
`ifdef PWM_CFG_ERRCNT_EN
    chk({tag, "_err"}, ErrCount, m_err);
`endif
  endtask

  task automatic do_reset();
    _RST = 1'b0;
    @(negedge CLK);
    _RST = 1'b1;
    m_reset();
  endtask

  task automatic period();
    PeriodEnd = 1'b1;
    @(negedge CLK);
    PeriodEnd = 1'b0;
    m_period();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fs,
                           input logic pe, input int gap);
    int w;
    for (int g = 0; g < gap; g++) @(negedge CLK);
    w = 0;
    while (!RxReady && w < 20) begin
      @(negedge CLK);
      w++;
    end
    if (!RxReady) chk("rx_ready_wait", RxReady, 1'b1);
    RxByte     = b;
    RxValid    = 1'b1;
    FrameStart = fs;
    PeriodEnd  = pe;
    @(negedge CLK);
    RxValid    = 1'b0;
    FrameStart = 1'b0;
    PeriodEnd  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input logic pe,
                            input logic rgap);
    for (int i = 0; i < f.size(); i++)
      send_byte(f[i], i == 0, pe && (i == f.size() - 1),
                rgap ? int'($urandom_range(0, 2)) : 0);
    if (pe) m_period();
    m_frame(f);
  endtask

  logic [7:0] fr[$];

  initial begin
    _RST = 1'b0; RxByte = '0; RxValid = 1'b0;
    FrameStart = 1'b0; PeriodEnd = 1'b0;
    m_reset();
    @(negedge CLK);
    @(negedge CLK);
    _RST = 1'b1;
    @(negedge CLK);
    check_all("reset");
    chk("reset_sel0_abs", SelectOut[7:0], 8'd6);

    fr = '{8'h03, 8'h02}; send_frame(fr, 1'b0, 1'b0);
    fr = '{8'h80};        send_frame(fr, 1'b0, 1'b0);
    chk("commit_pend", CommitPending, 1'b1);
    chk("commit_ready", RxReady, 1'b0);
    check_all("pre_apply");
    period();
    chk("ch3_sel_abs", SelectOut[31:24], 8'd2);
    check_all("apply1");

    fr = '{8'h45, 8'h12, 8'h34}; send_frame(fr, 1'b0, 1'b0);
    fr = '{8'h80};               send_frame(fr, 1'b0, 1'b0);
    period();
    chk("ch5_cnt_abs", CountOut[95:80], 16'h1234);
    fr = '{8'h45, 8'hAB}; send_frame(fr, 1'b0, 1'b0);
    fr = '{8'h80};        send_frame(fr, 1'b0, 1'b0);
    period();
    chk("ch5_cnt_partial", CountOut[95:80], 16'h1234);
    check_all("partial");

    fr = '{8'h03, 8'h05}; send_frame(fr, 1'b0, 1'b0);
    fr = '{8'h80};        send_frame(fr, 1'b1, 1'b0);
    chk("same_cyc_sel3", SelectOut[31:24], 8'd2);
    check_all("same_cyc");
    @(negedge CLK);
    period();
    chk("next_pe_sel3", SelectOut[31:24], 8'd5);
    check_all("next_pe");

    do_reset();
    fr = '{8'h0A, 8'h01}; send_frame(fr, 1'b0, 1'b0);
    fr = '{8'hC0};        send_frame(fr, 1'b0, 1'b0);
`ifdef PWM_CFG_ERRCNT_EN
    chk("err_two_abs", ErrCount, 8'd2);
`endif
    fr = '{8'h80}; send_frame(fr, 1'b0, 1'b0);
    period();
    check_all("invalid");
    for (int k = 0; k < 300; k++) begin
      fr = '{8'hC0}; send_frame(fr, 1'b0, 1'b0);
    end
`ifdef PWM_CFG_ERRCNT_EN
    chk("err_sat_abs", ErrCount, 8'd255);
`endif
    check_all("sat");

    fr = '{8'h01, 8'h03};        send_frame(fr, 1'b0, 1'b0);
    fr = '{8'h41, 8'h77, 8'h88}; send_frame(fr, 1'b0, 1'b0);
    fr = '{8'h80};               send_frame(fr, 1'b0, 1'b0);
    chk("rst_pend_before", CommitPending, 1'b1);
    do_reset();
    check_all("mid_commit_rst");
    period();
    check_all("after_rst_pe");

    for (int it = 0; it < 200; it++) begin
      int k;
      int ch;
      logic pe;
      k  = int'($urandom_range(0, 6));
      ch = int'($urandom_range(0, 9));
      pe = ($urandom_range(0, 3) == 0);
      fr.delete();
      unique case (k)
        0: fr = '{8'(ch), 8'($urandom)};
        1: fr = '{8'h40 | 8'(ch), 8'($urandom), 8'($urandom)};
        2: fr = '{8'h40 | 8'(ch), 8'($urandom)};
        3: fr = '{8'hC0 | 8'($urandom_range(0, 63))};
        4: fr = '{8'h80 | 8'($urandom_range(0, 63))};
        5: fr = '{8'(ch), 8'($urandom), 8'($urandom), 8'($urandom)};
        default: begin
          FrameStart = 1'b1;
          @(negedge CLK);
          FrameStart = 1'b0;
        end
      endcase
      send_frame(fr, pe, 1'b1);
      if (m_pend) begin
        chk("rnd_pend", CommitPending, 1'b1);
        for (int g = 0; g < int'($urandom_range(0, 3)); g++)
          @(negedge CLK);
        period();
      end else if ($urandom_range(0, 4) == 0) begin
        period();
      end
      check_all("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_config_regs.md
# pwm_config_regs

Command-decoding register bank that sits directly upstream of `PWMFrequencySelector` in the PWM IO expander. It consumes the byte stream delivered by the serial slave front end and holds per-channel shadow copies of the frequency `Select` code and the 16-bit `TimerSwitchCount`. On a commit command it transfers all shadows to the active outputs at the next PWM period boundary, so a channel never sees a half-updated configuration.

## Interface

**Parameters**

- `Channels`, default 8: number of PWM channels, 1..64.
- `DefaultSelect`, default 8'd6: reset `Select` code (4000 Hz; codes 0..6 = 50, 120, 200, 400, 1000, 2000, 4000 Hz).
- `DefaultCount`, default 16'd0: reset `TimerSwitchCount`.

**Ports**

- `CLK`  in  1  system clock, single clock domain.
- `_RST`  in  1  synchronous, active-low reset, sampled on the rising edge of `CLK`.
- `RxByte`  in  8  command byte from the serial front end.
- `RxValid`  in  1  `RxByte` is valid.
- `RxReady`  out  1  byte is accepted when `RxValid & RxReady`.
- `FrameStart`  in  1  one-cycle pulse marking the start of a new frame.
- `PeriodEnd`  in  1  one-cycle pulse at a PWM period boundary.
- `SelectOut`  out  8*Channels  active `Select` values; channel i occupies bits [8i+7:8i].
- `CountOut`  out  16*Channels  active `TimerSwitchCount` values; channel i occupies bits [16i+15:16i].
- `CommitPending`  out  1  a commit is waiting for `PeriodEnd`.
- `ErrCount`  out  8  invalid-frame counter; present only when `PWM_CFG_ERRCNT_EN` is defined.

## Operation

**Frame format**

- Byte 0 is the address byte: {`RegSel`[1:0], `Chan`[5:0]}.
- `RegSel` 00: one data byte follows and is written to the `Select` shadow of channel `Chan`.
- `RegSel` 01: two data bytes follow, high byte then low byte, written to the `Count` shadow of channel `Chan`.
- `RegSel` 10: commit. No data bytes follow, and `Chan` is ignored.
- `RegSel` 11: reserved; the frame is invalid.

**Parser FSM**

- States: `IDLE` (waiting for the address byte), `SEL_DATA`, `CNT_HI`, `CNT_LO`, `DISCARD`.
- `IDLE`: on an accepted byte, decode `RegSel`.
  - 00 → `SEL_DATA`.
  - 01 → `CNT_HI`.
  - 10 → set `CommitPending` and go to `DISCARD`.
  - 11 → `DISCARD`, counted as an error.
  - If `Chan >= Channels` for `RegSel` 00 or 01 → `DISCARD`, counted as an error.
- `SEL_DATA`: the accepted byte is written to the `Select` shadow; go to `DISCARD`.
- `CNT_HI`: the byte is latched into a temporary high register; go to `CNT_LO`.
- `CNT_LO`: the 16-bit `Count` shadow is written atomically as {temp, byte}; go to `DISCARD`.
- `DISCARD`: all further bytes are accepted and dropped.
- A `FrameStart` pulse forces the parser back to `IDLE` from any state. If a byte is accepted in the same cycle, that byte is parsed as the address byte.
- A frame that ends after `CNT_HI` leaves the shadow unchanged; the temp register is discarded.

**Commit**

- While `CommitPending` = 1, `RxReady` = 0, so no shadow can change mid-commit. `FrameStart` is still honoured.
- When `PeriodEnd` = 1 and `CommitPending` = 1, all shadows are copied to the active outputs and `CommitPending` is cleared.
- A commit command received while `CommitPending` = 1 is impossible, because `RxReady` is low.

## Timing

- **Reset** (`_RST` = 0 at an edge):
  - Every `SelectOut` lane and its shadow = `DefaultSelect`.
  - Every `CountOut` lane and its shadow = `DefaultCount`.
  - `CommitPending` = 0, `RxReady` = 1, FSM = `IDLE`, `ErrCount` = 0.
- Reset mid-frame or mid-commit discards everything; the pending commit is lost.
- Byte accepted at edge N: the shadow, temp register or state update is visible after edge N.
- Commit byte accepted at edge N: `CommitPending` = 1 and `RxReady` = 0 after edge N.
- `PeriodEnd` in the same cycle the commit byte is accepted does not apply the commit; the next `PeriodEnd` does.
- `PeriodEnd` sampled at edge M with `CommitPending` = 1: outputs update after edge M, and `CommitPending` = 0 / `RxReady` = 1 after edge M.
- `RxReady` is a registered output with no combinational path from `RxValid`.

## Configuration

- `PWM_CFG_ERRCNT_EN` defined:
  - The `ErrCount` port exists.
  - It increments once per invalid address byte (reserved `RegSel`, or channel out of range).
  - It saturates at 255.
  - It is cleared only by reset.
- `PWM_CFG_ERRCNT_EN` undefined: no `ErrCount` port or logic. Invalid frames are still discarded silently.

## Structure

- Package `pwm_cfg_pkg` holds:
  - `RegSel` codes (`REG_SELECT`, `REG_COUNT`, `REG_COMMIT`, `REG_RSVD`).
  - The parser state encoding.
  - The frequency code constants 0..6.
- Sub-module `pwm_cfg_frame_parser`: the FSM plus temp register. It emits write strobes (channel, is_count, 16-bit data) and a commit strobe.
- Top level holds the shadow arrays, the active arrays, commit logic and the optional counter.

## Test plan

- Reset, then idle: every `SelectOut` lane = 6, every `CountOut` lane = 0, `RxReady` = 1.
- Frame 0x03, 0x02: shadow `Select` of channel 3 = 2. Then frame 0x80: `CommitPending` = 1 and `RxReady` = 0. After `PeriodEnd`: `SelectOut` ch3 = 2, other lanes unchanged, `CommitPending` = 0.
- Frame 0x45, 0x12, 0x34, commit, `PeriodEnd`: `CountOut` ch5 = 16'h1234. Frame 0x45, 0xAB then `FrameStart`, commit, `PeriodEnd`: ch5 stays 16'h1234.
- Commit byte accepted in the same cycle as `PeriodEnd`: outputs unchanged; they update only after the following `PeriodEnd`.
- With `Channels` = 8: frame 0x0A, 0x01 and frame 0xC0 leave all shadows unchanged, and `ErrCount` = 2 (macro defined). 300 invalid frames leave `ErrCount` = 255.
- `_RST` low while `CommitPending` = 1 with modified shadows: all outputs return to defaults, `CommitPending` = 0, and a later `PeriodEnd` changes nothing.
